// File: rtl/mfcc_frame_pkg.sv
// mfcc_frame_pkg: shared default sizes and FSM encoding for the MFCC framer.
package mfcc_frame_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH      = 9;
  localparam int DEF_FRAME_LEN       = 256;
  localparam int DEF_HOP_LEN         = 128;
  localparam int DEF_FRAME_CNT_WIDTH = 8;

  // WAIT: not enough buffered samples for a frame; EMIT: replaying a frame;
  // RETIRE: one-cycle frame completion (base already advanced by HOP).
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    EMIT   = 2'd1,
    RETIRE = 2'd2
  } fs_state_e;

endpackage

// File: rtl/frame_ring_ram.sv
// frame_ring_ram: simple dual-port sample store, one write port and one
// registered read port with read enable. The read register doubles as the
// framer's output data register, so it holds when re_i is low.
module frame_ring_ram
  import mfcc_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; zeroed on reset/flush so out_data reads 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_o <= '0;
    else if (clear_i) rdata_o <= '0;
    else if (re_i)    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/frame_segmenter.sv
// frame_segmenter: buffers a PCM sample stream in a ring RAM and replays it
// as overlapping frames of FRAME_LEN samples, advancing HOP_LEN per frame.
module frame_segmenter
  import mfcc_frame_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int FRAME_LEN       = DEF_FRAME_LEN,
  parameter int HOP_LEN         = DEF_HOP_LEN,
  parameter int FRAME_CNT_WIDTH = DEF_FRAME_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic                       out_first,
  output logic                       out_last,
  output logic [ADDR_WIDTH-1:0]      out_idx,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_idx
);

  // Pointers carry one extra bit so full (occ == DEPTH) and empty differ.
  localparam int            PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FL_P    = PW'(FRAME_LEN);
  localparam logic [PW-1:0] FL_M1_P = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP_LEN);
  localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ADDR_WIDTH);

  fs_state_e                  state_q, state_d;
  logic [PW-1:0]              wp_q, wp_d, bp_q, bp_d, ro_q, ro_d;
  logic [PW-1:0]              occ;
  logic                       ready_en_q, ready_en_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_first_q, out_first_d;
  logic                       out_last_q, out_last_d;
  logic [ADDR_WIDTH-1:0]      out_idx_q, out_idx_d;
  logic                       frame_done_q, frame_done_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_idx_q, frame_idx_d;
  logic                       wr_en, rd_en, out_fire;
  logic [ADDR_WIDTH-1:0]      rd_addr;

  assign occ      = wp_q - bp_q;
  // ready_en_q keeps in_ready low for the first cycle after reset/flush.
  assign in_ready = ready_en_q & (occ < DEPTH_P);
  assign wr_en    = in_valid & in_ready & ~clear;
  assign out_fire = out_valid_q & out_ready;

  // Next-state logic: FSM, pointers, read issue and output-stage control.
  always_comb begin
    state_d      = state_q;
    wp_d         = wr_en ? wp_q + 1'b1 : wp_q;
    bp_d         = bp_q;
    ro_d         = ro_q;
    ready_en_d   = 1'b1;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_idx_d    = out_idx_q;
    frame_done_d = 1'b0;
    frame_idx_d  = frame_idx_q;
    rd_en        = 1'b0;
    rd_addr      = bp_q[ADDR_WIDTH-1:0] + ro_q[ADDR_WIDTH-1:0];

    unique case (state_q)
      WAIT: begin
        if (occ >= FL_P) state_d = EMIT;
      end
      EMIT: begin
        if (out_fire) out_valid_d = 1'b0;
        // Refill the output stage when it is empty or being consumed.
        if ((ro_q < FL_P) && (!out_valid_q || out_ready)) begin
          rd_en       = 1'b1;
          ro_d        = ro_q + 1'b1;
          out_valid_d = 1'b1;
          out_idx_d   = ro_q[ADDR_WIDTH-1:0];
          out_first_d = (ro_q == '0);
          out_last_d  = (ro_q == FL_M1_P);
        end
        // Last sample accepted: advance the frame base now so RETIRE sees
        // the post-hop occupancy.
        if (out_fire && out_last_q) begin
          state_d      = RETIRE;
          bp_d         = bp_q + HOP_P;
          ro_d         = '0;
          frame_done_d = 1'b1;
          frame_idx_d  = frame_idx_q + 1'b1;
        end
      end
      RETIRE: begin
        state_d = (occ >= FL_P) ? EMIT : WAIT;
      end
      default: state_d = WAIT;
    endcase

    // Soft flush overrides every handshake in the same cycle.
    if (clear) begin
      state_d      = WAIT;
      wp_d         = '0;
      bp_d         = '0;
      ro_d         = '0;
      ready_en_d   = 1'b0;
      out_valid_d  = 1'b0;
      out_first_d  = 1'b0;
      out_last_d   = 1'b0;
      out_idx_d    = '0;
      frame_done_d = 1'b0;
      frame_idx_d  = '0;
      rd_en        = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      wp_q         <= '0;
      bp_q         <= '0;
      ro_q         <= '0;
      ready_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_idx_q    <= '0;
      frame_done_q <= 1'b0;
      frame_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      bp_q         <= bp_d;
      ro_q         <= ro_d;
      ready_en_q   <= ready_en_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_idx_q    <= out_idx_d;
      frame_done_q <= frame_done_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

  frame_ring_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(clear),
    .we_i   (wr_en),
    .waddr_i(wp_q[ADDR_WIDTH-1:0]),
    .wdata_i(in_data),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(out_data)
  );

  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_idx    = out_idx_q;
  assign frame_done = frame_done_q;
  assign frame_idx  = frame_idx_q;

endmodule

// File: tb/tb_frame_segmenter.sv
// tb_frame_segmenter: directed + randomized stimulus against a frame-level
// reference model (frame k, sample i = k-th hop start + i of the accepted
// input stream).
module tb_frame_segmenter;

  localparam int DW = 16, AW = 4, FL = 8, HL = 4, FCW = 8, DEPTH = 16;

  logic           clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic           in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0]  in_data = '0;
  logic           in_ready, out_valid, out_first, out_last, frame_done;
  logic [DW-1:0]  out_data;
  logic [AW-1:0]  out_idx;
  logic [FCW-1:0] frame_idx;

  int n_tests = 0, n_fail = 0, cyc = 0, rdy_mode = 0;

  // Reference model state
  int sb [0:1023];
  int first_log [0:63];
  int last_log [0:63];
  int wr_cnt, fk, fi, done_cnt, nfirst, nlast;
  int first_valid_cyc, first_wr_cyc, first_valid_data, first_valid_idx;
  bit done_due, ready_block, stall_prev, saw_full;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_first, prev_last;

  frame_segmenter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL), .HOP_LEN(HL), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .out_idx(out_idx),
    .frame_done(frame_done), .frame_idx(frame_idx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    wr_cnt = 0; fk = 0; fi = 0; done_cnt = 0; nfirst = 0; nlast = 0;
    first_valid_cyc = -1; first_wr_cyc = -1; first_valid_data = -1; first_valid_idx = -1;
    done_due = 0; ready_block = 1; stall_prev = 0; saw_full = 0;
  endfunction

  // out_ready driver, applied 2 time units after each rising edge
  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Compare process: every falling edge, check DUT against the model
  initial begin
    int occ, pos;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        continue;
      end
      // frame completion pulse and counter
      if (done_due) done_cnt++;
      check("frame_done", int'(frame_done), int'(done_due));
      check("frame_idx", int'(frame_idx), done_cnt % 256);
      done_due = 0;
      // input readiness from buffer occupancy
      occ = wr_cnt - fk * HL;
      check("in_ready", int'(in_ready), (!ready_block && occ < DEPTH) ? 1 : 0);
      ready_block = 0;
      if (!in_ready && occ == DEPTH) saw_full = 1;
      // held outputs under backpressure
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(prev_data));
        check("hold_idx", int'(out_idx), int'(prev_idx));
        check("hold_first", int'(out_first), int'(prev_first));
        check("hold_last", int'(out_last), int'(prev_last));
      end
      // a frame is only emitted once all its samples have been accepted
      if (out_valid) check("frame_avail", (fk * HL + FL <= wr_cnt) ? 1 : 0, 1);
      if (out_valid && first_valid_cyc < 0) begin
        first_valid_cyc  = cyc;
        first_valid_data = int'(out_data);
        first_valid_idx  = int'(out_idx);
      end
      if (clear) begin
        model_reset();
        continue;
      end
      if (out_valid && out_ready) begin
        pos = fk * HL + fi;
        check("out_data", int'(out_data), (pos < 1024) ? sb[pos] : -1);
        check("out_idx", int'(out_idx), fi);
        check("out_first", int'(out_first), (fi == 0) ? 1 : 0);
        check("out_last", int'(out_last), (fi == FL - 1) ? 1 : 0);
        if (out_first && nfirst < 64) begin first_log[nfirst] = int'(out_data); nfirst++; end
        if (out_last && nlast < 64) begin last_log[nlast] = int'(out_data); nlast++; end
        fi++;
        if (fi == FL) begin fi = 0; fk++; done_due = 1; end
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data; prev_idx = out_idx; prev_first = out_first; prev_last = out_last;
      if (in_valid && in_ready && wr_cnt < 1024) begin
        if (wr_cnt == 0) first_wr_cyc = cyc;
        sb[wr_cnt] = int'(in_data);
        wr_cnt++;
      end
    end
  end

  // Offer one sample after `gap` idle cycles; call at posedge+1
  task automatic send(input int d, input int gap);
    int  g;
    logic t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    g = 0;
    do begin
      @(negedge clk); t = in_ready;
      @(posedge clk); #1; g++;
    end while (!t && g < 500);
    if (!t) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  // Wait for n model frames, idle, then confirm no extra frames appear
  task automatic wait_frames(input string tag, input int n);
    int g = 0;
    while (fk < n && g < 3000) begin @(negedge clk); #1; g++; end
    check({tag, "_timeout"}, (fk >= n) ? 1 : 0, 1);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    check({tag, "_frames"}, fk, n);
    check({tag, "_frame_idx"}, int'(frame_idx), n % 256);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_first", int'(out_first), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_idx", int'(frame_idx), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic framing + latency + retire with simultaneous write
    for (int v = 0; v < 16; v++) send(v, 0);
    wait_frames("basic", 3);
    check("latency", first_valid_cyc - first_wr_cyc, 10);
    check("lat_data", first_valid_data, 0);
    check("lat_idx", first_valid_idx, 0);
    check("basic_nfirst", nfirst, 3);
    check("basic_first0", first_log[0], 0);
    check("basic_first1", first_log[1], 4);
    check("basic_first2", first_log[2], 8);
    check("basic_last0", last_log[0], 7);
    check("basic_last1", last_log[1], 11);
    check("basic_last2", last_log[2], 15);

    // Backpressure on sample 3 of frame 0 while the input keeps streaming
    do_clear();
    fork
      begin
        for (int v = 0; v < 24; v++) send(v, 0);
      end
      begin
        int g = 0;
        while (!(out_valid && out_idx == 2) && g < 500) begin @(negedge clk); #1; g++; end
        check("bp_seen", (g < 500) ? 1 : 0, 1);
        @(posedge clk); #1; rdy_mode = 2;
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", int'(out_valid), 1);
          check("bp_data", int'(out_data), 3);
          check("bp_idx", int'(out_idx), 3);
        end
        @(posedge clk); #1; rdy_mode = 0;
      end
    join
    wait_frames("bp", 5);
    check("bp_full_stall", int'(saw_full), 1);

    // Wrap-around with random gaps and random out_ready
    do_clear();
    rdy_mode = 1;
    for (int v = 0; v < 64; v++)
      send(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    rdy_mode = 0;
    wait_frames("wrap", 15);
    check("wrap_first14", first_log[14], 56);
    check("wrap_last14", last_log[14], 63);

    // Long random run with random data
    do_clear();
    rdy_mode = 1;
    for (int v = 0; v < 200; v++)
      send(int'($urandom_range(0, 65535)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
    rdy_mode = 0;
    wait_frames("rand", 49);

    // Clear mid-frame after 5 samples of frame 1
    do_clear();
    for (int v = 0; v < 16; v++) send(v, 0);
    begin
      int g = 0;
      while (!(fk == 1 && fi == 5) && g < 500) begin @(negedge clk); #1; g++; end
      check("clr_reach", (g < 500) ? 1 : 0, 1);
    end
    do_clear();
    @(negedge clk);
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_out_data", int'(out_data), 0);
    check("clr_out_first", int'(out_first), 0);
    check("clr_out_last", int'(out_last), 0);
    check("clr_out_idx", int'(out_idx), 0);
    check("clr_frame_done", int'(frame_done), 0);
    check("clr_frame_idx", int'(frame_idx), 0);
    check("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    for (int v = 100; v < 108; v++) send(v, 0);
    wait_frames("clr", 1);
    check("clr_nfirst", nfirst, 1);
    check("clr_first0", first_log[0], 100);
    check("clr_last0", last_log[0], 107);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/frame_segmenter.md
Name: frame_segmenter

Overview:
- Streaming framer for the MFCC front end. Accepts the pre-emphasised PCM sample stream and stores it in a ring buffer.
- Re-emits the samples as overlapping frames of FRAME_LEN samples, advancing the frame start by HOP_LEN samples per frame.
- Drives the downstream windowing/FFT stage with valid/ready.
- Pulses frame_done once per completed frame; this pulse is the enable for the downstream frame counter.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- ADDR_WIDTH, 9, ring-buffer address width. DEPTH = 2**ADDR_WIDTH.
- FRAME_LEN, 256, samples per frame. Legal range 1..DEPTH.
- HOP_LEN, 128, frame advance in samples. Legal range 1..FRAME_LEN.
- FRAME_CNT_WIDTH, 8, width of frame_idx.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous soft flush of buffer and counters.
- in_valid, input, 1, input sample valid.
- in_data, input, DATA_WIDTH, input sample.
- in_ready, output, 1, buffer can accept a sample.
- out_valid, output, 1, out_data valid.
- out_data, output, DATA_WIDTH, frame sample.
- out_ready, input, 1, downstream accepts out_data.
- out_first, output, 1, qualifies sample 0 of a frame.
- out_last, output, 1, qualifies sample FRAME_LEN-1 of a frame.
- out_idx, output, ADDR_WIDTH, sample index within the frame.
- frame_done, output, 1, one-cycle pulse per completed frame.
- frame_idx, output, FRAME_CNT_WIDTH, number of completed frames, modulo 2**FRAME_CNT_WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and counters go to 0 and the FSM goes to WAIT. Outputs: in_ready=0, out_valid=0, out_data=0, out_first=0, out_last=0, out_idx=0, frame_done=0, frame_idx=0. in_ready rises on the first clk after reset is released.
- clear: same effect as reset, but synchronous. It takes priority over every handshake in the same cycle, and the sample offered in that cycle is dropped.
- Pointers:
  - wp (write) and bp (frame base) are ADDR_WIDTH+1 bits wide.
  - occ = wp - bp, modulo 2**(ADDR_WIDTH+1).
  - ro = read offset within the current frame, 0..FRAME_LEN-1.
- Input side:
  - in_ready = (occ < DEPTH).
  - A write happens when in_valid & in_ready: the sample is stored at wp[ADDR_WIDTH-1:0] and wp increments.
  - Samples are never overwritten before the frame base passes them.
- FSM states:
  - WAIT: go to EMIT when occ >= FRAME_LEN.
  - EMIT:
    - Reads go to address bp+ro using a synchronous-read RAM into an output register.
    - The first out_valid rises exactly 2 cycles after the cycle in which occ first reaches FRAME_LEN.
    - With out_ready held high, throughput is 1 sample per cycle.
    - If out_ready is low, out_data, out_first, out_last and out_idx stay stable, and no read advances.
    - out_valid must not drop until the handshake completes.
  - RETIRE: entered on the handshake with out_last. Actions:
    - bp += HOP_LEN and ro = 0.
    - frame_done=1 for exactly one cycle, in the cycle after that handshake.
    - frame_idx increments in the same cycle as frame_done and wraps to 0 after all-ones.
    - Next state is EMIT if occ (after the bp update) >= FRAME_LEN, else WAIT.
- Simultaneous events:
  - A write in the same cycle as retire gives occ_next = occ + 1 - HOP_LEN.
  - in_ready uses registered occ, so in_ready can only rise the cycle after retire.
- Arithmetic: all pointer arithmetic is modulo 2**(ADDR_WIDTH+1), so wrap-around of wp and bp across DEPTH is transparent.
- Overlap: samples bp+HOP_LEN..bp+FRAME_LEN-1 are re-read in the next frame.
- Reset mid-frame: the partial frame is discarded. There is no frame_done and frame_idx goes to 0.

Decomposition:
- Package mfcc_frame_pkg holds:
  - Default constants DATA_WIDTH, FRAME_LEN, HOP_LEN, ADDR_WIDTH.
  - FSM state encoding: WAIT=2'd0, EMIT=2'd1, RETIRE=2'd2.
- One sub-module, frame_ring_ram: a simple dual-port RAM of DEPTH x DATA_WIDTH with one write port and one synchronous-read port with read enable. No reset on the array.

Test Plan (FRAME_LEN=8, HOP_LEN=4, ADDR_WIDTH=4, out_ready=1 unless stated):
- Basic framing: stream samples 0..15 continuously -> frames output in order: frame 0 = 0..7, frame 1 = 4..11, frame 2 = 8..15. out_first is high on 0, 4 and 8; out_last is high on 7, 11 and 15. frame_done pulses 3 times; final frame_idx=3.
- Latency: 8 samples, one per cycle, starting at cycle 0 -> occ reaches 8 after the cycle-7 write; out_valid first high at cycle 10 with out_data=0 and out_idx=0.
- Backpressure: out_ready low for 5 cycles during sample 3 of frame 0 -> out_data=3 and out_idx=3 are held stable. Input stalls with in_ready=0 once occ=16. Samples resume intact with nothing lost or duplicated.
- Wrap-around: stream 64 samples (values 0..63) -> 15 frames; frame k = 4k..4k+7. Pointer wrap is invisible in the output data; frame_idx=15.
- Retire with simultaneous write: while frame 0 is ending, keep in_valid=1 -> occ after retire = prior occ + 1 - 4. No sample is dropped (check via scoreboard). frame_done stays high for 1 cycle only.
- Reset/clear mid-frame: assert clear after 5 samples of frame 1 have been output -> in the next cycle outputs are zero and frame_idx=0. A fresh stream 100..107 produces a single frame 100..107 with out_first on 100.
